vector_mem_sequencer: RTL and testbench

Controls the MEM stage of the vector processor. It splits each 192-bit vector load or store, held in the EX/MEM pipeline register, into per-lane word accesses on the narrow data-memory port. It stalls the upstream pipeline until the access completes and assembles the loaded vector for the MEM/WB register. Scalar accesses pass straight through in one cycle with no stall.

---
 rtl/vector_mem_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: MEM-stage controller for the vector processor.
// A 192-bit vector load/store is split into LANES word accesses on the narrow
// data-memory port while the upstream pipeline is stalled. Scalar accesses pass
// straight through combinationally. State advances on the falling clock edge.
// Optional feature: define VMEM_STRIDE_EN to add the i_stride port
// (lane i address = base + i*stride); otherwise the lane stride is fixed at 1.
module vector_mem_sequencer #(
  parameter int LANES  = 8,
  parameter int WORD_W = 24,
  parameter int ADDR_W = 21
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [3:0]              i_mem_op,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [LANES*WORD_W-1:0] i_store_vec,
`ifdef VMEM_STRIDE_EN
  input  logic [ADDR_W-1:0]       i_stride,
`endif
  input  logic [WORD_W-1:0]       i_mem_rdata,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic                    o_mem_we,
  output logic [WORD_W-1:0]       o_mem_wdata,
  output logic                    o_stall,
  output logic [LANES*WORD_W-1:0] o_load_vec,
  output logic                    o_load_valid,
  output logic                    o_busy
);

  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_prev_beat;
  logic                r_is_load;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_stride;
  logic [WORD_W-1:0]   w_store_lane [LANES];
  logic [WORD_W-1:0]   r_store_lane [LANES];
  logic [WORD_W-1:0]   r_load_lane  [LANES];

  // Decoded op with priority: vector store > vector load > scalar store > scalar load.
  logic w_vec_any;
  logic w_vec_store;
  logic w_vec_load;
  logic w_sc_store;
  logic w_sc_load;

  assign w_vec_any   = i_mem_op[3] | i_mem_op[2];
  assign w_vec_store = i_mem_op[3];
  assign w_vec_load  = ~i_mem_op[3] & i_mem_op[2];
  assign w_sc_store  = ~w_vec_any & i_mem_op[1];
  assign w_sc_load   = ~w_vec_any & ~i_mem_op[1] & i_mem_op[0];

  assign w_prev_beat = r_beat - 1'b1;

`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;
  assign w_stride = r_stride;
`else
  assign w_stride = ADDR_W'(1);
`endif

  // Lane views of the packed store input and the packed load output.
  for (genvar g = 0; g < LANES; g++) begin : g_lanes
    assign w_store_lane[g]               = i_store_vec[g*WORD_W +: WORD_W];
    assign o_load_vec[g*WORD_W +: WORD_W] = r_load_lane[g];
  end

  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_mem_wdata;
  logic              w_stall;
  logic              w_load_valid;

  // Next-state and memory-port decode; everything idles at zero by default.
  always_comb begin
    w_next_state = r_state;
    w_mem_addr   = '0;
    w_mem_we     = 1'b0;
    w_mem_wdata  = '0;
    w_stall      = 1'b0;
    w_load_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vec_any) begin
          w_stall      = 1'b1;
          w_next_state = w_vec_store ? S_WRITE : S_READ;
        end else if (w_sc_store) begin
          w_mem_addr  = i_base_addr;
          w_mem_we    = 1'b1;
          w_mem_wdata = w_store_lane[0];
        end else if (w_sc_load) begin
          w_mem_addr = i_base_addr;
        end
      end
      S_READ: begin
        w_stall    = 1'b1;
        w_mem_addr = r_addr;
        if (r_beat == LAST_BEAT) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_stall      = 1'b1;
        w_next_state = S_DONE;
      end
      S_WRITE: begin
        w_stall     = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_store_lane[r_beat];
        if (r_beat == LAST_BEAT) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_load_valid = r_is_load;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Reset forces every output low immediately, even with an op still presented.
  assign o_mem_addr   = i_rst ? '0   : w_mem_addr;
  assign o_mem_we     = i_rst ? 1'b0 : w_mem_we;
  assign o_mem_wdata  = i_rst ? '0   : w_mem_wdata;
  assign o_stall      = i_rst ? 1'b0 : w_stall;
  assign o_load_valid = i_rst ? 1'b0 : w_load_valid;
  assign o_busy       = (r_state != S_IDLE);

  // Control state, beat counter and assembled load lanes (cleared by reset).
  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_is_load <= 1'b0;
      for (int i = 0; i < LANES; i++) r_load_lane[i] <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_vec_any) begin
            r_beat    <= '0;
            r_is_load <= w_vec_load;
          end
        end
        S_READ: begin
          if (r_beat != '0) r_load_lane[w_prev_beat] <= i_mem_rdata;
          r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
        S_DRAIN: r_load_lane[LANES-1] <= i_mem_rdata;
        S_WRITE: r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        default: ;
      endcase
    end
  end

  // Operand latches: base/stride/store data captured on acceptance, lane address stepped per beat.
  always_ff @(negedge i_clk) begin
    if (r_state == S_IDLE && w_vec_any) begin
      r_addr <= i_base_addr;
`ifdef VMEM_STRIDE_EN
      r_stride <= i_stride;
`endif
      for (int i = 0; i < LANES; i++) r_store_lane[i] <= w_store_lane[i];
    end else if (r_state == S_READ || r_state == S_WRITE) begin
      r_addr <= r_addr + w_stride;
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: scoreboard bench for vector_mem_sequencer.
// Expected writes, read addresses and load vectors are queued as stimulus is
// driven and popped as the DUT produces them. Inputs change just after the
// falling (active) edge; outputs are sampled on the rising edge.
module tb_vector_mem_sequencer;

  localparam int LANES  = 8;
  localparam int WORD_W = 24;
  localparam int ADDR_W = 21;
  localparam int VEC_W  = LANES * WORD_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  logic              clk;
  logic              i_rst;
  logic [3:0]        i_mem_op;
  logic [ADDR_W-1:0] i_base_addr;
  logic [VEC_W-1:0]  i_store_vec;
  logic [WORD_W-1:0] i_mem_rdata;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [WORD_W-1:0] o_mem_wdata;
  logic              o_stall;
  logic [VEC_W-1:0]  o_load_vec;
  logic              o_load_valid;
  logic              o_busy;
`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] i_stride;
`endif

  int checks = 0;
  int errors = 0;

  wr_t               wr_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  logic [VEC_W-1:0]  ld_q[$];

  logic              s_stall, s_we, s_lv, s_busy;
  logic [ADDR_W-1:0] s_addr;
  logic [WORD_W-1:0] s_wdata;
  logic [VEC_W-1:0]  s_vec;
  logic [VEC_W-1:0]  last_load_vec;

  vector_mem_sequencer #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_mem_op     (i_mem_op),
    .i_base_addr  (i_base_addr),
    .i_store_vec  (i_store_vec),
`ifdef VMEM_STRIDE_EN
    .i_stride     (i_stride),
`endif
    .i_mem_rdata  (i_mem_rdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_wdata  (o_mem_wdata),
    .o_stall      (o_stall),
    .o_load_vec   (o_load_vec),
    .o_load_valid (o_load_valid),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a holds a + 0x100.
  function automatic logic [WORD_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
    return {3'b000, a} + 24'h000100;
  endfunction

  // Synchronous-read memory: data appears one falling edge after the address.
  always @(negedge clk) i_mem_rdata <= mem_model(o_mem_addr);

  function automatic logic [VEC_W-1:0] model_vec(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] stride);
    logic [VEC_W-1:0] v;
    logic [ADDR_W-1:0] a;
    v = '0;
    a = base;
    for (int i = 0; i < LANES; i++) begin
      v[i*WORD_W +: WORD_W] = mem_model(a);
      a = a + stride;
    end
    return v;
  endfunction

  task automatic push_reads(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride);
    logic [ADDR_W-1:0] a;
    a = base;
    for (int i = 0; i < LANES; i++) begin
      rd_q.push_back(a);
      a = a + stride;
    end
  endtask

  task automatic push_writes(input logic [ADDR_W-1:0] base, input logic [VEC_W-1:0] v,
                             input int count);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.addr = base + ADDR_W'(i);
      e.data = v[i*WORD_W +: WORD_W];
      wr_q.push_back(e);
    end
  endtask

  // One clock: sample at the rising edge, retire scoreboard entries, resume after the falling edge.
  task automatic tick();
    wr_t e;
    logic [ADDR_W-1:0] ea;
    logic [VEC_W-1:0] ev;
    @(posedge clk);
    s_stall = o_stall;  s_we = o_mem_we;  s_lv = o_load_valid;  s_busy = o_busy;
    s_addr  = o_mem_addr; s_wdata = o_mem_wdata; s_vec = o_load_vec;
    if (s_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%h data=%h required no write", s_addr, s_wdata);
      end else begin
        e = wr_q.pop_front();
        if (s_addr !== e.addr || s_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%h data=%h required addr=%h data=%h", s_addr, s_wdata, e.addr, e.data);
        end
      end
    end
    if (s_busy && s_stall && !s_we && rd_q.size() > 0) begin
      ea = rd_q.pop_front();
      checks++;
      if (s_addr !== ea) begin
        errors++;
        $display("FAIL read_addr got=%h required=%h", s_addr, ea);
      end
    end
    if (s_lv) begin
      checks++;
      if (ld_q.size() == 0) begin
        errors++;
        $display("FAIL load_valid_unexpected got=1 required=0");
      end else begin
        ev = ld_q.pop_front();
        if (s_vec !== ev) begin
          errors++;
          $display("FAIL load_vec got=%h required=%h", s_vec, ev);
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  // Present a vector op and hold it until the stall drops (the DONE cycle).
  task automatic run_vec(input logic [3:0] op, input logic [ADDR_W-1:0] base,
                         input logic [VEC_W-1:0] vec, output int stall_cnt,
                         output int lv_cnt, output bit timed_out);
    int n;
    stall_cnt = 0; lv_cnt = 0; n = 0;
    i_mem_op = op; i_base_addr = base; i_store_vec = vec;
    do begin
      tick();
      if (s_stall) stall_cnt++;
      if (s_lv) lv_cnt++;
      n++;
    end while (s_stall && n < 40);
    timed_out = s_stall;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({s_stall, s_we, s_lv, s_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=0000", {s_stall, s_we, s_lv, s_busy});
    end
    checks++;
    if (s_addr !== '0 || s_wdata !== '0) begin
      errors++;
      $display("FAIL reset_port addr=%h data=%h required 0", s_addr, s_wdata);
    end
    checks++;
    if (s_vec !== '0) begin
      errors++;
      $display("FAIL reset_load_vec got=%h required=0", s_vec);
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if (s_addr !== '0 || s_busy !== 1'b0 || s_stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs addr=%h busy=%b stall=%b required 0", s_addr, s_busy, s_stall);
    end
  endtask

  task automatic test_vector_store();
    logic [VEC_W-1:0] v;
    int sc, lc;
    bit to;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = WORD_W'(i + 1);
    push_writes(21'h00010, v, LANES);
    run_vec(4'b1000, 21'h00010, v, sc, lc, to);
    i_mem_op = 4'b0000;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL vst_timeout got=1 required=0"); end
    checks++;
    if (sc !== LANES + 1) begin errors++; $display("FAIL vst_stall_cycles got=%0d required=%0d", sc, LANES + 1); end
    checks++;
    if (lc !== 0) begin errors++; $display("FAIL vst_load_valid got=%0d required=0", lc); end
    checks++;
    if (wr_q.size() !== 0) begin errors++; $display("FAIL vst_writes_left got=%0d required=0", wr_q.size()); end
  endtask

  task automatic test_vector_load_wrap();
    int sc, lc;
    bit to;
    last_load_vec = model_vec(21'h1FFFFC, 21'd1);
    push_reads(21'h1FFFFC, 21'd1);
    ld_q.push_back(last_load_vec);
    run_vec(4'b0100, 21'h1FFFFC, '0, sc, lc, to);
    i_mem_op = 4'b0000;
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL vld_timeout got=1 required=0"); end
    checks++;
    if (sc !== LANES + 2) begin errors++; $display("FAIL vld_stall_cycles got=%0d required=%0d", sc, LANES + 2); end
    checks++;
    if (lc !== 1) begin errors++; $display("FAIL vld_load_valid got=%0d required=1", lc); end
    checks++;
    if (rd_q.size() !== 0 || ld_q.size() !== 0) begin
      errors++; $display("FAIL vld_queue_left got=%0d/%0d required=0/0", rd_q.size(), ld_q.size());
    end
    tick();
    checks++;
    if (s_vec !== last_load_vec || s_busy !== 1'b0) begin
      errors++; $display("FAIL vld_hold vec=%h busy=%b required vec=%h busy=0", s_vec, s_busy, last_load_vec);
    end
  endtask

  task automatic test_scalar();
    wr_t e;
    i_store_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, 24'hABCDEF};
    i_base_addr = 21'h00005;
    i_mem_op    = 4'b0010;
    e.addr = 21'h00005; e.data = 24'hABCDEF;
    wr_q.push_back(e);
    tick();
    checks++;
    if (s_stall !== 1'b0 || s_busy !== 1'b0 || s_we !== 1'b1) begin
      errors++; $display("FAIL sst_ctrl stall=%b busy=%b we=%b required 0,0,1", s_stall, s_busy, s_we);
    end
    i_store_vec[WORD_W-1:0] = 24'h123456;
    i_base_addr = 21'h00007;
    i_mem_op    = 4'b0011;
    e.addr = 21'h00007; e.data = 24'h123456;
    wr_q.push_back(e);
    tick();
    checks++;
    if (wr_q.size() !== 0) begin errors++; $display("FAIL sst_writes_left got=%0d required=0", wr_q.size()); end
    i_base_addr = 21'h1ABCD;
    i_mem_op    = 4'b0001;
    tick();
    checks++;
    if (s_addr !== 21'h1ABCD || s_we !== 1'b0 || s_stall !== 1'b0) begin
      errors++; $display("FAIL sld addr=%h we=%b stall=%b required 1abcd,0,0", s_addr, s_we, s_stall);
    end
    i_mem_op = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    logic [VEC_W-1:0] v;
    int sc, lc;
    bit to;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    push_writes(21'h00100, v, LANES);
    run_vec(4'b1100, 21'h00100, v, sc, lc, to);
    i_mem_op = 4'b0000;
    checks++;
    if (to !== 1'b0 || sc !== LANES + 1) begin
      errors++; $display("FAIL prio_stall got=%0d timeout=%b required=%0d", sc, to, LANES + 1);
    end
    checks++;
    if (lc !== 0 || wr_q.size() !== 0) begin
      errors++; $display("FAIL prio_store lv=%0d writes_left=%0d required 0,0", lc, wr_q.size());
    end
    tick();
    checks++;
    if (s_vec !== last_load_vec) begin
      errors++; $display("FAIL prio_load_vec_hold got=%h required=%h", s_vec, last_load_vec);
    end
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] v;
    int sc1, lc1, sc2, lc2;
    bit to1, to2;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = WORD_W'(24'h500000 + i);
    push_writes(21'h00200, v, LANES);
    run_vec(4'b1000, 21'h00200, v, sc1, lc1, to1);
    last_load_vec = model_vec(21'h00040, 21'd1);
    push_reads(21'h00040, 21'd1);
    ld_q.push_back(last_load_vec);
    run_vec(4'b0100, 21'h00040, v, sc2, lc2, to2);
    i_mem_op = 4'b0000;
    checks++;
    if (to1 !== 1'b0 || sc1 !== LANES + 1 || lc1 !== 0) begin
      errors++; $display("FAIL b2b_store stall=%0d lv=%0d timeout=%b required %0d,0,0", sc1, lc1, to1, LANES + 1);
    end
    checks++;
    if (to2 !== 1'b0 || sc2 !== LANES + 2 || lc2 !== 1) begin
      errors++; $display("FAIL b2b_load stall=%0d lv=%0d timeout=%b required %0d,1,0", sc2, lc2, to2, LANES + 2);
    end
    checks++;
    if (wr_q.size() !== 0 || rd_q.size() !== 0 || ld_q.size() !== 0) begin
      errors++; $display("FAIL b2b_queue_left got=%0d/%0d/%0d required 0/0/0", wr_q.size(), rd_q.size(), ld_q.size());
    end
    tick();
  endtask

`ifdef VMEM_STRIDE_EN
  task automatic test_stride();
    int sc, lc;
    bit to;
    i_stride = 21'd3;
    last_load_vec = model_vec(21'h00000, 21'd3);
    push_reads(21'h00000, 21'd3);
    ld_q.push_back(last_load_vec);
    run_vec(4'b0100, 21'h00000, '0, sc, lc, to);
    i_mem_op = 4'b0000;
    checks++;
    if (to !== 1'b0 || sc !== LANES + 2 || lc !== 1) begin
      errors++; $display("FAIL stride_load stall=%0d lv=%0d timeout=%b required %0d,1,0", sc, lc, to, LANES + 2);
    end
    checks++;
    if (rd_q.size() !== 0 || ld_q.size() !== 0) begin
      errors++; $display("FAIL stride_queue_left got=%0d/%0d required 0/0", rd_q.size(), ld_q.size());
    end
    i_stride = 21'd1;
    tick();
  endtask
`endif

  task automatic test_reset_mid_store();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = WORD_W'(24'hC00000 + i);
    push_writes(21'h00300, v, 3);
    i_mem_op = 4'b1000; i_base_addr = 21'h00300; i_store_vec = v;
    for (int i = 0; i < 4; i++) tick();
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_stall, o_mem_we, o_load_valid, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_ctrl got=%b required=0000", {o_stall, o_mem_we, o_load_valid, o_busy});
    end
    checks++;
    if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_load_vec !== '0) begin
      errors++; $display("FAIL rst_mid_data addr=%h wdata=%h vec=%h required 0", o_mem_addr, o_mem_wdata, o_load_vec);
    end
    i_mem_op = 4'b0000;
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_we !== 1'b0 || s_busy !== 1'b0 || s_stall !== 1'b0) begin
        errors++; $display("FAIL rst_after we=%b busy=%b stall=%b required 0,0,0", s_we, s_busy, s_stall);
      end
    end
    checks++;
    if (wr_q.size() !== 0) begin errors++; $display("FAIL rst_writes_left got=%0d required=0", wr_q.size()); end
  endtask

  initial begin
    i_rst       = 1'b1;
    i_mem_op    = 4'b0000;
    i_base_addr = '0;
    i_store_vec = '0;
`ifdef VMEM_STRIDE_EN
    i_stride    = 21'd1;
`endif
    last_load_vec = '0;
    @(negedge clk);
    #1;
    test_reset();
    test_vector_store();
    test_vector_load_wrap();
    test_scalar();
    test_priority();
    test_back_to_back();
`ifdef VMEM_STRIDE_EN
    test_stride();
`endif
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
